// File: rtl/vend_change.sv
// vend_change: newspaper vending controller with coin edge detection,
// configurable price, change return and cancel/refund. Credit and change
// are tracked in 5-cent units; change is paid out one nickel per clock.
module vend_change #(
    parameter int PRICE     = 3,
    parameter int CREDIT_W  = 4,
    parameter int CHANGE_EN = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                newspaper,
    output logic                nickel_out,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        VEND   = 2'b01,
        CHANGE = 2'b10
    } state_t;

    localparam logic [CREDIT_W-1:0] ZERO_C    = {CREDIT_W{1'b0}};
    localparam logic [CREDIT_W-1:0] ONE_C     = {{(CREDIT_W-1){1'b0}}, 1'b1};
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam bit                  CHANGE_ON = (CHANGE_EN != 0);

    // Coin code to value in nickels: nickel 1, dime 2, quarter 5.
    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W-1:0] val;
        case (code)
            2'd1:    val = ONE_C;
            2'd2:    val = CREDIT_W'(2);
            2'd3:    val = CREDIT_W'(5);
            default: val = ZERO_C;
        endcase
        return val;
    endfunction

    state_t              state_r, state_s;
    logic [1:0]          coin_q_r;
    logic [CREDIT_W-1:0] credit_r, credit_s;
    logic [CREDIT_W-1:0] pending_r, pending_s;
    logic                reject_r, reject_s;
    logic                newspaper_r, newspaper_s;
    logic                nickel_r, nickel_s;
    logic                busy_r, busy_s;
    logic                coin_event_s;
    logic [CREDIT_W-1:0] sum_s;

    // A coin counts once, on the sample where it first appears after zero.
    assign coin_event_s = (coin != 2'd0) && (coin_q_r == 2'd0);
    // Cannot overflow: credit in IDLE is at most PRICE-1 and a coin adds at most 5.
    assign sum_s        = credit_r + coin_value(coin);

    // State, datapath and registered outputs; reset aborts everything at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            coin_q_r    <= 2'd0;
            credit_r    <= ZERO_C;
            pending_r   <= ZERO_C;
            reject_r    <= 1'b0;
            newspaper_r <= 1'b0;
            nickel_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            coin_q_r    <= coin;
            credit_r    <= credit_s;
            pending_r   <= pending_s;
            reject_r    <= reject_s;
            newspaper_r <= newspaper_s;
            nickel_r    <= nickel_s;
            busy_r      <= busy_s;
        end
    end

    // Next state, next credit/pending and coin rejection decision.
    always_comb begin
        state_s   = state_r;
        credit_s  = credit_r;
        pending_s = pending_r;
        reject_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cancel) begin
                    // Cancel wins over any coin arriving in the same cycle.
                    reject_s = coin_event_s;
                    if (credit_r != ZERO_C) begin
                        state_s   = CHANGE;
                        pending_s = credit_r;
                        credit_s  = ZERO_C;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (coin_event_s) begin
                    if (sum_s >= PRICE_C) begin
                        state_s   = VEND;
                        credit_s  = ZERO_C;
                        pending_s = CHANGE_ON ? (sum_s - PRICE_C) : ZERO_C;
                    end else begin
                        credit_s = sum_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            VEND: begin
                reject_s = coin_event_s;
                if (pending_r != ZERO_C) begin
                    state_s = CHANGE;
                end else begin
                    state_s = IDLE;
                end
            end
            CHANGE: begin
                reject_s  = coin_event_s;
                pending_s = pending_r - ONE_C;
                if (pending_r == ONE_C) begin
                    state_s = IDLE;
                end else begin
                    state_s = CHANGE;
                end
            end
            default: begin
                state_s   = IDLE;
                credit_s  = ZERO_C;
                pending_s = ZERO_C;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they leave a flop.
    always_comb begin
        newspaper_s = 1'b0;
        nickel_s    = 1'b0;
        busy_s      = 1'b0;
        case (state_s)
            IDLE: begin
                busy_s = 1'b0;
            end
            VEND: begin
                newspaper_s = 1'b1;
                busy_s      = 1'b1;
            end
            CHANGE: begin
                nickel_s = 1'b1;
                busy_s   = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign newspaper   = newspaper_r;
    assign nickel_out  = nickel_r;
    assign coin_reject = reject_r;
    assign credit      = credit_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_vend_change.sv
// Directed bench for vend_change: PRICE=3 with change (dut) and without (dut0).
module tb_vend_change;

    logic       clock;
    logic       reset;
    logic [1:0] coin;
    logic       cancel;

    logic       newspaper, nickel_out, coin_reject, busy;
    logic [3:0] credit;
    logic       newspaper0, nickel_out0, coin_reject0, busy0;
    logic [3:0] credit0;

    int errors = 0;
    int checks = 0;

    vend_change #(.PRICE(3), .CREDIT_W(4), .CHANGE_EN(1)) dut (
        .clock(clock), .reset(reset), .coin(coin), .cancel(cancel),
        .newspaper(newspaper), .nickel_out(nickel_out), .coin_reject(coin_reject),
        .credit(credit), .busy(busy)
    );

    vend_change #(.PRICE(3), .CREDIT_W(4), .CHANGE_EN(0)) dut0 (
        .clock(clock), .reset(reset), .coin(coin), .cancel(cancel),
        .newspaper(newspaper0), .nickel_out(nickel_out0), .coin_reject(coin_reject0),
        .credit(credit0), .busy(busy0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Check the full output set of the CHANGE_EN=1 instance.
    task automatic chk_all(input string tag, input logic np, input logic nk,
                           input logic rj, input logic [3:0] cr, input logic bz);
        chk({tag, ".newspaper"}, {31'd0, newspaper}, {31'd0, np});
        chk({tag, ".nickel_out"}, {31'd0, nickel_out}, {31'd0, nk});
        chk({tag, ".coin_reject"}, {31'd0, coin_reject}, {31'd0, rj});
        chk({tag, ".credit"}, {28'd0, credit}, {28'd0, cr});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
    endtask

    initial begin
        reset  = 1'b1;
        coin   = 2'd0;
        cancel = 1'b0;
        step();
        step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        step();
        chk_all("idle_after_reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Three nickels with idle gaps.
        coin = 2'd1; step(); chk_all("n3.first", 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
        coin = 2'd0; step();
        coin = 2'd1; step(); chk_all("n3.second", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        coin = 2'd0; step();
        coin = 2'd1; step(); chk_all("n3.vend", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        coin = 2'd0; step(); chk_all("n3.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Nickel then dime: exact price, no change.
        coin = 2'd1; step(); chk_all("nd.credit", 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
        coin = 2'd0; step();
        coin = 2'd2; step(); chk_all("nd.vend", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        coin = 2'd0; step(); chk_all("nd.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Two dimes: one nickel back with change, none without.
        coin = 2'd2; step(); chk_all("dd.credit", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        coin = 2'd0; step();
        coin = 2'd2; step(); chk_all("dd.vend", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("dd.nc.newspaper", {31'd0, newspaper0}, 32'd1);
        coin = 2'd0; step(); chk_all("dd.change", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("dd.nc.nickel_out", {31'd0, nickel_out0}, 32'd0);
        chk("dd.nc.busy", {31'd0, busy0}, 32'd0);
        step(); chk_all("dd.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Quarter: newspaper at N+1, nickels at N+2 and N+3, busy for 3 cycles.
        coin = 2'd3; step(); chk_all("q.vend", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("q.nc.newspaper", {31'd0, newspaper0}, 32'd1);
        coin = 2'd0; step(); chk_all("q.change1", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("q.nc.nickel_out", {31'd0, nickel_out0}, 32'd0);
        step(); chk_all("q.change2", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        step(); chk_all("q.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Dime held three cycles counts once, then cancel refunds it.
        coin = 2'd2; step(); chk_all("hold.c1", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        step(); chk_all("hold.c2", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        step(); chk_all("hold.c3", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        coin = 2'd0; cancel = 1'b1;
        step(); chk_all("cancel.r1", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("cancel.nc.nickel_out", {31'd0, nickel_out0}, 32'd1);
        cancel = 1'b0;
        step(); chk_all("cancel.r2", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        step(); chk_all("cancel.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Coin inserted during CHANGE is rejected; payout unaffected.
        coin = 2'd3; step(); chk_all("rej.vend", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        coin = 2'd0; step(); chk_all("rej.change1", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        coin = 2'd1; step(); chk_all("rej.pulse", 1'b0, 1'b1, 1'b1, 4'd0, 1'b1);
        coin = 2'd0; step(); chk_all("rej.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Reset in the middle of CHANGE clears outputs immediately.
        coin = 2'd3; step(); chk_all("rst.vend", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        coin = 2'd0; step(); chk_all("rst.change", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("rst.immediate", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        // A coin present as reset releases counts as an event.
        coin = 2'd1;
        step(); chk_all("rst.held", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        step(); chk_all("rst.release_coin", 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);

        // Cancel refunds the single nickel.
        coin = 2'd0; cancel = 1'b1;
        step(); chk_all("refund1.pay", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        cancel = 1'b0;
        step(); chk_all("refund1.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Cancel with zero credit is ignored; a simultaneous coin is rejected.
        coin = 2'd2; cancel = 1'b1;
        step(); chk_all("cancel0.reject", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        coin = 2'd0; cancel = 1'b0;
        step(); chk_all("cancel0.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_change.md
# vend_change

Parametrised newspaper vending controller with coin edge detection, configurable price, change return and cancel/refund. It accepts nickel, dime and quarter coin codes, tracks credit in 5-cent units and asserts a one-cycle `newspaper` pulse when credit reaches `PRICE`. Any excess or refunded credit is paid out one nickel per clock. It is the drop-in successor to the fixed 15-cent, no-change vending FSM used in the lab designs.

## Interface
- `PRICE`, default 3: item price in nickels; legal range 1..(2^`CREDIT_W` − 5).
- `CREDIT_W`, default 4: credit/change register width; 2^`CREDIT_W` must be greater than `PRICE`+4.
- `CHANGE_EN`, default 1: 1 returns the excess over `PRICE`; 0 forfeits it. Refunds are always returned.
- `clock` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `coin` input, 2 bits: 0 none, 1 nickel (1 unit), 2 dime (2 units), 3 quarter (5 units).
- `cancel` input, 1 bit: level; request a refund of the current credit.
- `newspaper` output, 1 bit: one-cycle dispense pulse.
- `nickel_out` output, 1 bit: high for one cycle per nickel returned.
- `coin_reject` output, 1 bit: one-cycle pulse when a coin edge is not accepted.
- `credit` output, `CREDIT_W` bits: accumulated credit in nickels.
- `busy` output, 1 bit: high when the state is not IDLE.

## Operation
- **Edge detection:**
  - `coin_q` registers the previous `coin` sample.
  - A coin event is `coin`≠0 while `coin_q`==0.
  - A coin held for several cycles counts once.
  - A nonzero `coin` at reset release counts as an event.
- **States:** IDLE, VEND, CHANGE. All outputs are registered or Moore.
- **IDLE, coin event, no cancel:**
  - sum = `credit` + value.
  - If sum ≥ `PRICE`: go to VEND, `credit`←0, `pending`←sum−`PRICE` (0 if `CHANGE_EN`=0).
  - Otherwise: stay in IDLE, `credit`←sum.
- **IDLE, cancel, `credit`>0:**
  - Go to CHANGE, `pending`←`credit`, `credit`←0.
  - A coin event in the same cycle is rejected (`coin_reject`=1) and not credited. Cancel has priority.
- **IDLE, cancel, `credit`=0:** ignored. A coin event in the same cycle is also rejected.
- **VEND:**
  - `newspaper`=1 for exactly one cycle.
  - Next state is CHANGE if `pending`>0, else IDLE.
- **CHANGE:**
  - `nickel_out`=1 every cycle.
  - `pending` decrements each cycle.
  - Return to IDLE on the edge where `pending`==1.
  - `nickel_out` stays high for exactly the original `pending` count of cycles.
- **Coin event in VEND or CHANGE:** `coin_reject` pulses in the next cycle; `credit` and `pending` are unchanged.
- **Cancel in VEND or CHANGE:** ignored.
- **Overflow:** none is possible given the `CREDIT_W` constraint. The maximum sum is `PRICE`+4.

## Timing
- **Reset values (asynchronous, immediate):**
  - State IDLE.
  - `credit`, `pending`, `coin_q` = 0.
  - `newspaper`, `nickel_out`, `coin_reject` = 0; `busy`=0.
- **Reset mid-operation:**
  - Aborts vending and payout immediately.
  - Pending change and credit are lost.
- **Latency, completing coin:**
  - Coin event sampled at edge N.
  - `newspaper` high during cycle N+1.
  - First `nickel_out` in cycle N+2.
- **Latency, non-completing coin:** `credit` updates at edge N, visible in cycle N+1.
- **Latency, cancel:**
  - Cancel sampled at edge N.
  - `nickel_out` from cycle N+1 for `credit` cycles.
- **`coin_reject`:** registered; high for the cycle after the rejected event.
- **Back-to-back transactions:** the next coin is accepted in the first IDLE cycle after VEND or CHANGE, provided `coin` has returned to 0 for at least one sample.

## Test plan
- `PRICE`=3, `CHANGE_EN`=1. Drive three nickels, each held one cycle with idle gaps. Required: `credit` 1 then 2, then one `newspaper` pulse, `credit`=0, no `nickel_out`.
- Drive a nickel, then a dime. Required: one `newspaper` pulse, zero `nickel_out` cycles.
- Drive two dimes. Required: `newspaper` pulse, then `nickel_out` for 1 cycle. Rerun with `CHANGE_EN`=0: `newspaper` pulse only, no `nickel_out`.
- Drive one quarter. Required: `newspaper` in cycle N+1, `nickel_out` in cycles N+2 and N+3, `busy` high for 3 cycles.
- Hold a dime for 3 cycles, then assert cancel. Required: `credit`=2 (counted once), then `nickel_out` for 2 cycles, `credit`=0, no `newspaper`.
- Insert a coin during CHANGE. Required: `coin_reject` pulse, payout unaffected. Then assert `reset` mid-CHANGE. Required: all outputs 0 immediately and `nickel_out` stops.
